// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: combinational one-hot grant, registered broadcast on the next edge.
// Losing units are not buffered and must hold their request until acked; flush blocks grants for the cycle.
module cdb_arbiter #(
  parameter int  NUM_UNITS  = 4,
  parameter int  TAG_WIDTH  = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  CNT_WIDTH  = 16,
  localparam int PTR_WIDTH  = $clog2(NUM_UNITS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_UNITS-1:0]            req_valid,
  input  logic [NUM_UNITS*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_UNITS-1:0]            req_ack,
  output logic                            cdb_valid,
  output logic [TAG_WIDTH-1:0]            cdb_tag,
  output logic [DATA_WIDTH-1:0]           cdb_data,
  output logic [NUM_UNITS-1:0]            cdb_src,
  output logic [PTR_WIDTH-1:0]            rr_ptr,
  output logic [CNT_WIDTH-1:0]            conflict_cnt
);

  logic [PTR_WIDTH:0]   scan;
  logic [PTR_WIDTH-1:0] win;
  logic [PTR_WIDTH-1:0] next_ptr;
  logic                 found;
  logic                 grant;
  logic                 multi;

  // Scan from rr_ptr upward with modulo wrap; one extra bit keeps non-power-of-two counts exact.
  always_comb begin
    scan  = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      scan = {1'b0, rr_ptr} + (PTR_WIDTH+1)'(k);
      if (scan >= (PTR_WIDTH+1)'(NUM_UNITS))
        scan = scan - (PTR_WIDTH+1)'(NUM_UNITS);
      if (!found && req_valid[scan[PTR_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = scan[PTR_WIDTH-1:0];
      end
    end
  end

  // rst only gates the visible ack, so it never feeds a flop's data path.
  always_comb begin
    grant    = found & ~flush;
    multi    = |(req_valid & (req_valid - 1'b1));
    next_ptr = (win == PTR_WIDTH'(NUM_UNITS - 1)) ? '0 : win + 1'b1;
    req_ack  = '0;
    if (grant && !rst)
      req_ack = NUM_UNITS'(1) << win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid    <= 1'b0;
      cdb_tag      <= '0;
      cdb_data     <= '0;
      cdb_src      <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (!flush && multi && conflict_cnt != {CNT_WIDTH{1'b1}})
        conflict_cnt <= conflict_cnt + 1'b1;
      if (grant) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= req_tag[win*TAG_WIDTH +: TAG_WIDTH];
        cdb_data  <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
        cdb_src   <= NUM_UNITS'(1) << win;
        rr_ptr    <= next_ptr;
      end else begin
        // Tag/data deliberately hold so idle cycles do not toggle the wide bus.
        cdb_valid <= 1'b0;
        cdb_src   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int PW = 2;
  localparam int SW = 1 + TW + DW + N + PW + CW + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [N-1:0]  req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ack;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [N-1:0]  cdb_src;
  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] conflict_cnt;

  logic [N-1:0]  s_ack;
  logic          s_valid;
  logic [TW-1:0] s_tag;
  logic [DW-1:0] s_data;
  logic [N-1:0]  s_src;
  logic [PW-1:0] s_ptr;
  logic [3:0]    s_cnt;

  cdb_arbiter #(.NUM_UNITS(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_ack(req_ack), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .rr_ptr(rr_ptr), .conflict_cnt(conflict_cnt)
  );

  cdb_arbiter #(.NUM_UNITS(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_ack(s_ack), .cdb_valid(s_valid), .cdb_tag(s_tag),
    .cdb_data(s_data), .cdb_src(s_src), .rr_ptr(s_ptr), .conflict_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_src;
  int            m_ptr;
  int            m_cnt;
  int            m_cnt4;

  task automatic model_reset();
    m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = '0;
    m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  function automatic int model_winner();
    if (rst || flush) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ack();
    int w = model_winner();
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    if (!flush && $countones(req_valid) >= 2) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    w = model_winner();
    if (w < 0) begin
      m_valid = 1'b0;
      m_src   = '0;
    end else begin
      m_valid = 1'b1;
      m_tag   = req_tag[w*TW +: TW];
      m_data  = req_data[w*DW +: DW];
      m_src   = N'(1) << w;
      m_ptr   = (w + 1) % N;
    end
  endtask

  function automatic logic [SW-1:0] exp_state();
    return {m_valid, m_tag, m_data, m_src, PW'(m_ptr), CW'(m_cnt), 4'(m_cnt4)};
  endfunction

  function automatic logic [SW-1:0] obs_state();
    return {cdb_valid, cdb_tag, cdb_data, cdb_src, rr_ptr, conflict_cnt, s_cnt};
  endfunction

  task automatic randomize_payload();
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = TW'($urandom);
      req_data[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req_valid = N'($urandom) | 4'b0001;
    randomize_payload();
    model_reset();
    #2;
    checks++;
    if (req_ack !== '0) begin errors++; $display("FAIL reset_ack got %b want 0000", req_ack); end
    checks++;
    if (obs_state() !== '0) begin errors++; $display("FAIL reset_state got %h want 0", obs_state()); end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ack !== '0) begin errors++; $display("FAIL idle_ack c%0d got %b want 0000", c, req_ack); end
      @(posedge clk); model_edge(); #1;
      checks++;
      if ({cdb_valid, rr_ptr, conflict_cnt} !== '0 || obs_state() !== exp_state())
        begin errors++; $display("FAIL idle_state c%0d got %h want %h", c, obs_state(), exp_state()); end
    end
  endtask

  task automatic test_single();
    req_tag = '0; req_data = '0; flush = 1'b0;
    req_valid = 4'b0010;
    req_tag[1*TW +: TW]  = 4'd3;
    req_data[1*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (req_ack !== 4'b0010) begin errors++; $display("FAIL single_ack got %b want 0010", req_ack); end
    @(posedge clk); model_edge(); #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_src, rr_ptr} !== {1'b1, 4'd3, 32'hDEAD_BEEF, 4'b0010, 2'd2})
      begin errors++; $display("FAIL single_bcast got %b %h %h %b %0d want 1 3 deadbeef 0010 2",
                               cdb_valid, cdb_tag, cdb_data, cdb_src, rr_ptr); end
    checks++;
    if (obs_state() !== exp_state()) begin errors++; $display("FAIL single_state got %h want %h", obs_state(), exp_state()); end
    req_valid = '0;
  endtask

  task automatic test_rotation();
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      randomize_payload();
      #1;
      checks++;
      if (req_ack !== N'(1) << (c % N) || req_ack !== model_ack())
        begin errors++; $display("FAIL rot_ack c%0d got %b want %b", c, req_ack, N'(1) << (c % N)); end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (cdb_src !== N'(1) << (c % N) || obs_state() !== exp_state())
        begin errors++; $display("FAIL rot_state c%0d got %h want %h", c, obs_state(), exp_state()); end
    end
    checks++;
    if (conflict_cnt !== 16'd5) begin errors++; $display("FAIL rot_cnt got %0d want 5", conflict_cnt); end
    req_valid = '0;
  endtask

  task automatic test_wrap_skip();
    logic [N-1:0]  reqs [3];
    logic [N-1:0]  acks [3];
    logic [PW-1:0] ptrs [3];
    reqs = '{4'b0100, 4'b0101, 4'b0101};
    acks = '{4'b0100, 4'b0001, 4'b0100};
    ptrs = '{2'd3, 2'd1, 2'd3};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = reqs[c];
      randomize_payload();
      #1;
      checks++;
      if (req_ack !== acks[c] || req_ack !== model_ack())
        begin errors++; $display("FAIL wrap_ack c%0d got %b want %b", c, req_ack, acks[c]); end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (rr_ptr !== ptrs[c] || obs_state() !== exp_state())
        begin errors++; $display("FAIL wrap_state c%0d ptr %0d want %0d state %h want %h",
                                 c, rr_ptr, ptrs[c], obs_state(), exp_state()); end
    end
  endtask

  task automatic test_flush();
    int saved_ptr, saved_cnt;
    saved_ptr = m_ptr; saved_cnt = m_cnt;
    req_valid = 4'b0011; flush = 1'b1;
    randomize_payload();
    #1;
    checks++;
    if (req_ack !== '0) begin errors++; $display("FAIL flush_ack got %b want 0000", req_ack); end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_src !== '0 || rr_ptr !== PW'(saved_ptr) || conflict_cnt !== CW'(saved_cnt))
      begin errors++; $display("FAIL flush_state got v%b src%b ptr%0d cnt%0d want v0 src0000 ptr%0d cnt%0d",
                               cdb_valid, cdb_src, rr_ptr, conflict_cnt, saved_ptr, saved_cnt); end
    flush = 1'b0;
    #1;
    checks++;
    if (req_ack !== 4'b0001 || req_ack !== model_ack())
      begin errors++; $display("FAIL flush_resume_ack got %b want 0001", req_ack); end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (obs_state() !== exp_state()) begin errors++; $display("FAIL flush_resume got %h want %h", obs_state(), exp_state()); end
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    req_valid = 4'b1000; flush = 1'b0;
    randomize_payload();
    @(posedge clk); model_edge(); #1;
    checks++;
    if (cdb_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %b want 1", cdb_valid); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_state() !== '0 || req_ack !== '0)
      begin errors++; $display("FAIL arst_now got %h ack %b want 0 ack 0000", obs_state(), req_ack); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); model_edge(); #1;
    checks++;
    if (obs_state() !== exp_state()) begin errors++; $display("FAIL arst_after got %h want %h", obs_state(), exp_state()); end
    req_valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    req_valid = 4'b0110;
    randomize_payload();
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (req_ack !== model_ack()) begin errors++; $display("FAIL sat_ack c%0d got %b want %b", c, req_ack, model_ack()); end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (obs_state() !== exp_state()) begin errors++; $display("FAIL sat_state c%0d got %h want %h", c, obs_state(), exp_state()); end
    end
    checks++;
    if (s_cnt !== 4'd15 || conflict_cnt !== 16'd20)
      begin errors++; $display("FAIL sat_cnt got %0d/%0d want 15/20", s_cnt, conflict_cnt); end
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      randomize_payload();
      #1;
      checks++;
      if (req_ack !== model_ack())
        begin errors++; $display("FAIL rand_ack c%0d got %b want %b", c, req_ack, model_ack()); end
      checks++;
      if ((req_ack & ~req_valid) !== '0 || $countones(req_ack) > 1)
        begin errors++; $display("FAIL rand_onehot c%0d got %b req %b", c, req_ack, req_valid); end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (obs_state() !== exp_state())
        begin errors++; $display("FAIL rand_state c%0d got %h want %h", c, obs_state(), exp_state()); end
    end
    flush = 1'b0; req_valid = '0;
  endtask

  initial begin
    req_tag = '0; req_data = '0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
